pixel_line_fetch: RTL

Per-line pixel fetch stage that sits directly upstream of the display output path and is paced by the video timing generator's `new_line`/`new_pixel`/`vblank` strobes. At the start of every visible line it reads a line's worth of 16-bit words from video memory over a req/ack handshake into a small FIFO. It then hands out one 8-bit pixel (CLUT index) per `new_pixel` strobe, high byte first, and flags underflow when memory cannot keep up.

---
 rtl/pixel_fetch_pkg.sv | 14 +
 rtl/pixel_line_fetch_if.sv | 24 ++
 rtl/sync_fifo.sv | 63 ++++++
 rtl/pixel_line_fetch.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/pixel_fetch_pkg.sv
// pixel_fetch_pkg: shared types and constants for the line fetch stage.
// FSM state enum, default address width, underflow fill byte.
package pixel_fetch_pkg;

  localparam int ADDR_W_DEF = 22;
  localparam logic [7:0] UNDERFLOW_FILL = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_ABORT
  } fetch_state_e;

endpackage

// File: rtl/pixel_line_fetch_if.sv
// pixel_line_fetch_if: video memory read port (req/addr out, ack/data in).
// master = fetch stage, slave = memory; ack marks data valid same cycle.
interface pixel_line_fetch_if
  import pixel_fetch_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
);

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [15:0]       mem_data;

  modport master (
    output mem_req, mem_addr,
    input  mem_ack, mem_data
  );

  modport slave (
    input  mem_req, mem_addr,
    output mem_ack, mem_data
  );

endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO, flush/push/pop, count/full/empty.
// Ports: clk, rst_n, flush, push, din, pop, dout, count, full, empty.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    do_push = push & ~flush & (cnt_q != CW'(DEPTH));
    do_pop  = pop & ~flush & (cnt_q != '0);
    wr_d    = wr_q + AW'(do_push);
    rd_d    = rd_q + AW'(do_pop);
    cnt_d   = cnt_q + CW'(do_push) - CW'(do_pop);
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end

  assign dout  = mem_q[rd_q];
  assign count = cnt_q;
  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);

endmodule

// File: rtl/pixel_line_fetch.sv
// pixel_line_fetch: per-line word fetch into FIFO, one byte out per new_pixel.
// Ports: timing strobes, line params, mem (master), pixel/valid/underflow; +underflow_count with PIXEL_FETCH_UNDERFLOW_CNT_EN.
module pixel_line_fetch
  import pixel_fetch_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W     = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              new_line,
  input  logic              new_pixel,
  input  logic              vblank,
  input  logic [ADDR_W-1:0] line_base,
  input  logic [8:0]        words_per_line,
  pixel_line_fetch_if.master mem,
  output logic [7:0]        pixel,
  output logic              pixel_valid,
  output logic              underflow
`ifdef PIXEL_FETCH_UNDERFLOW_CNT_EN
  ,
  output logic [15:0]       underflow_count
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [8:0]        rem_q, rem_d;
  logic [ADDR_W-1:0] lbase_q, lbase_d;
  logic [8:0]        lcnt_q, lcnt_d;
  logic              sel_q, sel_d;
  logic [7:0]        pixel_q, pixel_d;
  logic              valid_q, valid_d;
  logic              under_q, under_d;

  logic              line_start;
  logic              req;
  logic              push;
  logic              pop;
  logic [15:0]       head;
  logic [CW-1:0]     fcount;
  logic              full_unused;
  logic              empty;

  assign line_start = new_line & ~vblank;

  assign req = ((state_q == ST_FETCH) && (fcount < CW'(FIFO_DEPTH)))
             || (state_q == ST_ABORT);

  assign mem.mem_req  = req;
  assign mem.mem_addr = addr_q;

  sync_fifo #(
    .WIDTH (16),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset_n),
    .flush (line_start),
    .push  (push),
    .din   (mem.mem_data),
    .pop   (pop),
    .dout  (head),
    .count (fcount),
    .full  (full_unused),
    .empty (empty)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    lbase_d = lbase_q;
    lcnt_d  = lcnt_q;
    push    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (line_start) begin
          addr_d  = line_base;
          rem_d   = words_per_line;
          state_d = (words_per_line != '0) ? ST_FETCH : ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (line_start) begin
          // an outstanding request must be drained before restarting
          if (req && !mem.mem_ack) begin
            lbase_d = line_base;
            lcnt_d  = words_per_line;
            state_d = ST_ABORT;
          end else begin
            addr_d  = line_base;
            rem_d   = words_per_line;
            state_d = (words_per_line != '0) ? ST_FETCH : ST_IDLE;
          end
        end else if (req && mem.mem_ack) begin
          push   = 1'b1;
          addr_d = addr_q + ADDR_W'(1);
          rem_d  = rem_q - 9'd1;
          if (rem_q == 9'd1) state_d = ST_IDLE;
        end
      end
      ST_ABORT: begin
        if (line_start) begin
          lbase_d = line_base;
          lcnt_d  = words_per_line;
        end
        if (mem.mem_ack) begin
          addr_d  = lbase_d;
          rem_d   = lcnt_d;
          state_d = (lcnt_d != '0) ? ST_FETCH : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // sel_q: 0 = high byte next, 1 = low byte next
  always_comb begin
    sel_d   = sel_q;
    pixel_d = pixel_q;
    under_d = under_q;
    valid_d = new_pixel;
    pop     = 1'b0;
    if (new_pixel) begin
      if (empty) begin
        pixel_d = UNDERFLOW_FILL;
        under_d = 1'b1;
      end else begin
        pixel_d = sel_q ? head[7:0] : head[15:8];
        pop     = sel_q;
        sel_d   = ~sel_q;
      end
    end
    if (line_start) begin
      sel_d   = 1'b0;
      under_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      lbase_q <= '0;
      lcnt_q  <= '0;
      sel_q   <= 1'b0;
      pixel_q <= '0;
      valid_q <= 1'b0;
      under_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      lbase_q <= lbase_d;
      lcnt_q  <= lcnt_d;
      sel_q   <= sel_d;
      pixel_q <= pixel_d;
      valid_q <= valid_d;
      under_q <= under_d;
    end
  end

  assign pixel       = pixel_q;
  assign pixel_valid = valid_q;
  assign underflow   = under_q;

`ifdef PIXEL_FETCH_UNDERFLOW_CNT_EN
  logic [15:0] ucnt_q, ucnt_d;

  always_comb begin
    ucnt_d = ucnt_q;
    if (new_pixel && empty && (ucnt_q != 16'hFFFF))
      ucnt_d = ucnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ucnt_q <= '0;
    else          ucnt_q <= ucnt_d;
  end

  assign underflow_count = ucnt_q;
`endif

endmodule
